// File: rtl/geogenius_pkg.sv
// Shared definitions for the Genius game engine: FSM state codes,
// LFSR geometry/taps and default parameter values.
package geogenius_pkg;

  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARA     = 4'h1,
    GERA        = 4'h2,
    MOSTRA      = 4'h3,
    PAUSA       = 4'h4,
    ESPERA      = 4'h5,
    COMPARA     = 4'h6,
    PROXIMA     = 4'h7,
    FIM_GANHOU  = 4'hA,
    FIM_PERDEU  = 4'hB,
    FIM_TIMEOUT = 4'hC
  } estado_t;

  // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
  localparam int unsigned LFSR_W         = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASCARA = 16'hB400;

  localparam int unsigned DEF_N_BOTOES    = 8;
  localparam int unsigned DEF_MAX_RODADAS = 16;
  localparam int unsigned DEF_T_LED       = 1000;
  localparam int unsigned DEF_T_PAUSA     = 500;
  localparam int unsigned DEF_T_TIMEOUT   = 5000;
  localparam logic [LFSR_W-1:0] DEF_SEMENTE = 16'hACE1;

  function automatic logic [LFSR_W-1:0] lfsr_passo(input logic [LFSR_W-1:0] v);
    return {v[LFSR_W-2:0], ^(v & LFSR_MASCARA)};
  endfunction

endpackage

// File: rtl/geogenius_param_if.sv
// Board-side bundle of the Genius engine: player controls in, LEDs,
// result flags and debug displays out.
interface geogenius_param_if #(
  parameter int unsigned N_BOTOES    = 8,
  parameter int unsigned MAX_RODADAS = 16
);
  localparam int unsigned RW = $clog2(MAX_RODADAS + 1);

  logic                jogar;
  logic                dificuldade;
  logic [N_BOTOES-1:0] botoes;
  logic [N_BOTOES-1:0] leds;
  logic                ganhou;
  logic                perdeu;
  logic                timeout;
  logic                pronto;
  logic [RW-1:0]       score;
  logic [3:0]          db_estado;
  logic [RW-1:0]       db_rodada;

  // board / player side
  modport master (
    output jogar, dificuldade, botoes,
    input  leds, ganhou, perdeu, timeout, pronto, score, db_estado, db_rodada
  );

  // game engine side
  modport slave (
    input  jogar, dificuldade, botoes,
    output leds, ganhou, perdeu, timeout, pronto, score, db_estado, db_rodada
  );
endinterface

// File: rtl/geogenius_param_memoria_sequencia.sv
// Sequence store: one symbol per round, synchronous write, asynchronous read.
module memoria_sequencia #(
  parameter int unsigned PROF = 16,
  parameter int unsigned LARG = 3,
  parameter int unsigned AW   = 4
) (
  input  logic            clock,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [LARG-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [LARG-1:0] rdata
);
  logic [LARG-1:0] mem [PROF];

  // write port
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/geogenius_param.sv
// Parametrised Genius (Simon) game engine.
// Optional feature: define GEOGENIUS_TIMEOUT_EN to enable the per-press
// timeout (FIM_TIMEOUT); otherwise ESPERA waits indefinitely.
module geogenius_param
  import geogenius_pkg::*;
#(
  parameter int unsigned N_BOTOES    = DEF_N_BOTOES,
  parameter int unsigned MAX_RODADAS = DEF_MAX_RODADAS,
  parameter int unsigned T_LED       = DEF_T_LED,
  parameter int unsigned T_PAUSA     = DEF_T_PAUSA,
  parameter int unsigned T_TIMEOUT   = DEF_T_TIMEOUT,
  parameter logic [LFSR_W-1:0] SEMENTE = DEF_SEMENTE
) (
  input logic clock,
  input logic reset,
  geogenius_param_if.slave bus
);
  localparam int unsigned K    = $clog2(N_BOTOES);
  localparam int unsigned RW   = $clog2(MAX_RODADAS + 1);
  localparam int unsigned AW   = $clog2(MAX_RODADAS);
  localparam int unsigned TMAX = (T_LED > T_PAUSA) ? T_LED : T_PAUSA;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam logic [RW-1:0] UM = RW'(1);

  estado_t             estado, prox;
  logic [LFSR_W-1:0]   lfsr;
  logic [RW-1:0]       rodada, indice, score, limite;
  logic [TW-1:0]       tempo;
  logic [K-1:0]        simbolo, mem_dado;
  logic [N_BOTOES-1:0] capt, leds_q;
  logic                botao_ant, press, acerto, expirou;
  logic                ganhou_q, perdeu_q, pronto_q;

  function automatic logic [N_BOTOES-1:0] um_quente(input logic [K-1:0] s);
    return N_BOTOES'(1) << s;
  endfunction

  memoria_sequencia #(
    .PROF (MAX_RODADAS),
    .LARG (K),
    .AW   (AW)
  ) u_mem (
    .clock (clock),
    .we    (estado == GERA),
    .waddr (rodada[AW-1:0]),
    .wdata (simbolo),
    .raddr (indice[AW-1:0]),
    .rdata (mem_dado)
  );

  // free-running symbol source
  always_ff @(posedge clock) begin
    if (reset) lfsr <= SEMENTE;
    else       lfsr <= lfsr_passo(lfsr);
  end

  // fold the low LFSR bits into 0..N_BOTOES-1
  always_comb begin
    simbolo = lfsr[K-1:0];
    if ({1'b0, lfsr[K-1:0]} >= (K+1)'(N_BOTOES)) simbolo = lfsr[K-1:0] - K'(N_BOTOES);
  end

  assign press  = (estado == ESPERA) && (|bus.botoes) && !botao_ant;
  // comparing against a one-hot pattern also rejects multi-button presses
  assign acerto = (capt == um_quente(mem_dado));

`ifdef GEOGENIUS_TIMEOUT_EN
  localparam int unsigned TOW = $clog2(T_TIMEOUT + 1);
  logic [TOW-1:0] cnt_espera;
  logic           timeout_q;

  // press timer, held at zero outside ESPERA so each entry starts fresh
  always_ff @(posedge clock) begin
    if (reset || estado != ESPERA) cnt_espera <= '0;
    else if (!expirou)             cnt_espera <= cnt_espera + TOW'(1);
  end

  assign expirou = (cnt_espera == TOW'(T_TIMEOUT - 1));

  // timeout flag aligned with the state register
  always_ff @(posedge clock) begin
    if (reset) timeout_q <= 1'b0;
    else       timeout_q <= (prox == FIM_TIMEOUT);
  end

  assign bus.timeout = timeout_q;
`else
  assign expirou     = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // next-state logic
  always_comb begin
    prox = estado;
    unique case (estado)
      INICIAL: if (bus.jogar) prox = PREPARA;
      PREPARA: prox = GERA;
      GERA:    prox = MOSTRA;
      MOSTRA:  if (tempo == TW'(T_LED - 1)) prox = PAUSA;
      PAUSA:   if (tempo == TW'(T_PAUSA - 1)) prox = (indice + UM < rodada) ? MOSTRA : ESPERA;
      ESPERA: begin
        if (press)        prox = COMPARA;
        else if (expirou) prox = FIM_TIMEOUT;
      end
      COMPARA: prox = acerto ? PROXIMA : FIM_PERDEU;
      PROXIMA: begin
        if (indice + UM < rodada)   prox = ESPERA;
        else if (score + UM == limite) prox = FIM_GANHOU;
        else                        prox = GERA;
      end
      FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT: if (bus.jogar) prox = PREPARA;
      default: prox = INICIAL;
    endcase
  end

  // state register and game datapath
  always_ff @(posedge clock) begin
    if (reset) begin
      estado    <= INICIAL;
      rodada    <= '0;
      indice    <= '0;
      score     <= '0;
      limite    <= '0;
      tempo     <= '0;
      capt      <= '0;
      botao_ant <= 1'b0;
    end else begin
      estado    <= prox;
      botao_ant <= |bus.botoes;
      if (prox != estado || !(estado inside {MOSTRA, PAUSA})) tempo <= '0;
      else                                                     tempo <= tempo + TW'(1);
      unique case (estado)
        PREPARA: begin
          score  <= '0;
          rodada <= '0;
          indice <= '0;
          limite <= bus.dificuldade ? RW'(MAX_RODADAS) : RW'(MAX_RODADAS / 2);
        end
        GERA: begin
          rodada <= rodada + UM;
          indice <= '0;
        end
        PAUSA: begin
          if (prox == MOSTRA)      indice <= indice + UM;
          else if (prox == ESPERA) indice <= '0;
        end
        ESPERA:  if (press) capt <= bus.botoes;
        PROXIMA: begin
          if (prox == ESPERA) indice <= indice + UM;
          else                score  <= score + UM;
        end
        default: ;
      endcase
    end
  end

  // registered LEDs and result flags
  always_ff @(posedge clock) begin
    if (reset) begin
      leds_q   <= '0;
      ganhou_q <= 1'b0;
      perdeu_q <= 1'b0;
      pronto_q <= 1'b0;
    end else begin
      leds_q   <= (estado == MOSTRA) ? um_quente(mem_dado) : '0;
      ganhou_q <= (prox == FIM_GANHOU);
      perdeu_q <= (prox == FIM_PERDEU);
      pronto_q <= prox inside {FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT};
    end
  end

  assign bus.leds      = leds_q;
  assign bus.ganhou    = ganhou_q;
  assign bus.perdeu    = perdeu_q;
  assign bus.pronto    = pronto_q;
  assign bus.score     = score;
  assign bus.db_estado = estado;
  assign bus.db_rodada = rodada;
endmodule

// File: doc/geogenius_param.md
# geogenius_param

Parametrised Genius (Simon) game engine: generates a pseudo-random sequence of N_BOTOES symbols, replays it on the LEDs one round longer each time, and checks the player's presses against it. It is the self-contained successor to the fixed 8-button top level: it sits between board buttons/LEDs and the score/state 7-segment decoders. Sequence length, button count, difficulty limit and all timings are parameters.

## Interface
- N_BOTOES, 8: number of buttons/LEDs, 2..16
- MAX_RODADAS, 16: rounds to win in hard mode, 2..64; easy mode wins at MAX_RODADAS/2
- T_LED, 1000: cycles each sequence LED stays lit
- T_PAUSA, 500: dark cycles after each lit LED
- T_TIMEOUT, 5000: cycles allowed per press (see Configuration)
- SEMENTE, 16'hACE1: LFSR reset value, nonzero
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- jogar  in  1  start/restart request, level-sampled
- dificuldade  in  1  0 easy, 1 hard; sampled on game start
- botoes  in  N_BOTOES  raw (already debounced) buttons, active-high
- leds  out  N_BOTOES  one-hot during display, else 0
- ganhou, perdeu, timeout  out  1  result flags, held in terminal states
- pronto  out  1  high in any terminal state
- score  out  clog2(MAX_RODADAS+1)  completed rounds
- db_estado  out  4  FSM state code
- db_rodada  out  clog2(MAX_RODADAS+1)  current round length

## Operation
- 16-bit Fibonacci LFSR (taps 16,14,13,11) free-runs every cycle from SEMENTE after reset.
- New symbol = LFSR[k-1:0], k=clog2(N_BOTOES); if ≥ N_BOTOES, subtract N_BOTOES.
- States/codes: INICIAL 0, PREPARA 1, GERA 2, MOSTRA 3, PAUSA 4, ESPERA 5, COMPARA 6, PROXIMA 7, FIM_GANHOU A, FIM_PERDEU B, FIM_TIMEOUT C.
- INICIAL: outputs 0; jogar → PREPARA.
- PREPARA: score, rodada, índice cleared; limit latched from dificuldade → GERA.
- GERA: writes new symbol at address rodada, rodada++ → MOSTRA with índice=0.
- MOSTRA: leds = one-hot(mem[índice]) for T_LED cycles → PAUSA.
- PAUSA: leds=0 for T_PAUSA cycles; índice++; if índice<rodada → MOSTRA, else índice=0 → ESPERA.
- ESPERA: press = rising edge of OR(botoes) (registered previous value). Press → COMPARA with botoes captured.
- COMPARA: captured value one-hot and equal to one-hot(mem[índice]) → PROXIMA; otherwise (wrong or multi-bit) → FIM_PERDEU.
- PROXIMA: if índice<rodada-1, índice++ → ESPERA; else score++; score==limit → FIM_GANHOU, else → GERA.
- Terminal states hold flags, score and leds=0; jogar → PREPARA (new game, LFSR not reseeded).
- jogar ignored outside INICIAL/terminal states; botoes ignored outside ESPERA; a button held across entry to ESPERA does not count until released and re-pressed.

## Timing
- All outputs registered; reset values: leds 0, flags 0, pronto 0, score 0, db_estado 0, db_rodada 0.
- Reset in any state: next cycle INICIAL, sequence memory contents don't-care.
- jogar high in INICIAL → PREPARA next cycle; first LED lights 3 cycles after jogar sampled.
- Display of round r: r·(T_LED+T_PAUSA) cycles.
- Press decision: flags/next state visible 2 cycles after the rising edge of botoes.
- Press in the same cycle the timeout count expires: press wins.

## Configuration
- GEOGENIUS_TIMEOUT_EN defined: counter cleared on entry to ESPERA; reaching T_TIMEOUT cycles without a press → FIM_TIMEOUT (timeout=1, perdeu=0).
- Undefined: no counter instantiated, ESPERA waits indefinitely, timeout tied 0, FIM_TIMEOUT unreachable.

## Structure
- Package geogenius_pkg: state codes, LFSR width/taps/tap mask, default parameters.
- Sub-module memoria_sequencia: MAX_RODADAS × clog2(N_BOTOES) synchronous-write, asynchronous-read register file.

## Test plan
Bench: N_BOTOES=4, MAX_RODADAS=4, T_LED=4, T_PAUSA=2, T_TIMEOUT=20; bench records leds during display and replays.
- Reset then jogar pulse, dificuldade=1, replay correctly every round → ganhou=1, pronto=1, score=4 after round 4, leds=0.
- dificuldade=0, correct replay → ganhou after 2 rounds, score=2.
- Round 2, press wrong button on second symbol → perdeu=1, score=1, db_estado=B.
- Press two buttons simultaneously in ESPERA → perdeu=1.
- With GEOGENIUS_TIMEOUT_EN, no press for 20 cycles in ESPERA → timeout=1, perdeu=0, db_estado=C; without macro, still ESPERA after 100 cycles.
- reset asserted mid-MOSTRA → next cycle db_estado=0, leds=0, score=0; jogar restarts cleanly.
